// File: rtl/eth_frame_gen_64_pkg.sv
// Shared definitions for the 64-bit Ethernet frame generator: FSM states,
// frame geometry constants and the last-beat byte-enable helper.
package eth_frame_gen_64_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int HDR_LEN = 14;
  localparam int LANES   = 8;

  // Byte enables for the final beat given L mod 8 (0 means a full beat).
  function automatic logic [7:0] keep_from_rem(input logic [2:0] rem);
    logic [2:0] shift;
    shift = 3'(4'd8 - {1'b0, rem});
    return 8'hff >> shift;
  endfunction

endpackage

// File: rtl/eth_frame_gen_64.sv
// Transmit-side Ethernet frame source: builds header plus counting payload
// and streams it as 64-bit AXI-Stream beats with tkeep, honouring
// backpressure and a programmable inter-frame gap. All outputs registered.
module eth_frame_gen_64
  import eth_frame_gen_64_pkg::*;
#(
  parameter int MAX_LEN   = 1514,
  parameter int MIN_LEN   = 14,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic [47:0]          dst_mac,
  input  logic [47:0]          src_mac,
  input  logic [15:0]          ethertype,
  input  logic [7:0]           ifg_cycles,
  output logic [63:0]          m_axis_tdata,
  output logic [7:0]           m_axis_tkeep,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 m_axis_tuser,
  output logic                 busy,
  output logic [31:0]          frame_count
);

  state_e      state_q, state_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic [15:0] len_q, len_d;
  logic [47:0] dst_q, dst_d;
  logic [47:0] src_q, src_d;
  logic [15:0] etype_q, etype_d;
  logic [7:0]  ifg_q, ifg_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] off_q, off_d;
  logic [63:0] tdata_q, tdata_d;
  logic [7:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        tvalid_q, tvalid_d;
  logic        busy_q, busy_d;

  logic        launch, advance, stop;
  logic [15:0] cur_len, cur_off;
  logic [47:0] cur_dst, cur_src;
  logic [15:0] cur_etype;
  logic [7:0]  cur_seq;
  logic [63:0] beat_data;
  logic [7:0]  beat_keep;
  logic        beat_last;

  // Requested length is compared at full width, then held in 16 bits.
  function automatic logic [15:0] clamp_len(input logic [LEN_WIDTH-1:0] req);
    if (req > LEN_WIDTH'(MAX_LEN))      return 16'(MAX_LEN);
    else if (req < LEN_WIDTH'(MIN_LEN)) return 16'(MIN_LEN);
    else                                return 16'(req);
  endfunction

  // Byte at absolute frame position idx: header, counting payload, or 0 past the end.
  function automatic logic [7:0] frame_byte(input logic [15:0] idx, input logic [15:0] len,
                                            input logic [47:0] dst, input logic [47:0] src,
                                            input logic [15:0] etype, input logic [7:0] seq);
    logic [15:0] k;
    logic [7:0]  b;
    k = idx - 16'(HDR_LEN);
    b = 8'h00;
    if (idx >= len) begin
      b = 8'h00;
    end else if (idx < 16'(HDR_LEN)) begin
      case (idx[3:0])
        4'd0:    b = dst[47:40];
        4'd1:    b = dst[39:32];
        4'd2:    b = dst[31:24];
        4'd3:    b = dst[23:16];
        4'd4:    b = dst[15:8];
        4'd5:    b = dst[7:0];
        4'd6:    b = src[47:40];
        4'd7:    b = src[39:32];
        4'd8:    b = src[31:24];
        4'd9:    b = src[23:16];
        4'd10:   b = src[15:8];
        4'd11:   b = src[7:0];
        4'd12:   b = etype[15:8];
        4'd13:   b = etype[7:0];
        default: b = 8'h00;
      endcase
    end else begin
      b = seq + k[7:0];
    end
    return b;
  endfunction

  // Next-state logic: decides when a frame starts, advances, or ends.
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    frame_count_d = frame_count_q;
    launch        = 1'b0;
    advance       = 1'b0;
    stop          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          launch  = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tvalid_q && m_axis_tready) begin
          if (tlast_q) begin
            frame_count_d = frame_count_q + 32'd1;
            if (ifg_q == 8'd0 && enable) begin
              launch = 1'b1;
            end else if (ifg_q != 8'd0) begin
              stop    = 1'b1;
              state_d = ST_GAP;
              gap_d   = ifg_q;
            end else begin
              stop    = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_q > 8'd1) begin
          gap_d = gap_q - 8'd1;
        end else if (enable) begin
          launch  = 1'b1;
          state_d = ST_SEND;
          gap_d   = 8'd0;
        end else begin
          state_d = ST_IDLE;
          gap_d   = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new frame takes its config straight from the inputs; otherwise use the latched copy.
  assign cur_len   = launch ? clamp_len(frame_len) : len_q;
  assign cur_dst   = launch ? dst_mac : dst_q;
  assign cur_src   = launch ? src_mac : src_q;
  assign cur_etype = launch ? ethertype : etype_q;
  assign cur_seq   = launch ? frame_count_d[7:0] : seq_q;
  assign cur_off   = launch ? 16'd0 : off_q + 16'(LANES);

  // Assemble the next beat lane by lane, with tkeep/tlast from the remaining length.
  always_comb begin
    beat_data = 64'd0;
    for (int j = 0; j < LANES; j++) begin
      beat_data[8*j +: 8] = frame_byte(cur_off + 16'(j), cur_len, cur_dst, cur_src,
                                       cur_etype, cur_seq);
    end
    beat_last = (cur_off + 16'(LANES)) >= cur_len;
    beat_keep = beat_last ? keep_from_rem(cur_len[2:0]) : 8'hff;
  end

  // Datapath: latch config on launch, load beats on handshake, hold under backpressure.
  always_comb begin
    len_d    = len_q;
    dst_d    = dst_q;
    src_d    = src_q;
    etype_d  = etype_q;
    ifg_d    = ifg_q;
    seq_d    = seq_q;
    off_d    = off_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (launch) begin
      len_d    = cur_len;
      dst_d    = cur_dst;
      src_d    = cur_src;
      etype_d  = cur_etype;
      ifg_d    = ifg_cycles;
      seq_d    = cur_seq;
      off_d    = cur_off;
      tdata_d  = beat_data;
      tkeep_d  = beat_keep;
      tlast_d  = beat_last;
      tvalid_d = 1'b1;
    end else if (advance) begin
      off_d   = cur_off;
      tdata_d = beat_data;
      tkeep_d = beat_keep;
      tlast_d = beat_last;
    end else if (stop) begin
      tdata_d  = 64'd0;
      tkeep_d  = 8'd0;
      tlast_d  = 1'b0;
      tvalid_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      gap_q         <= 8'd0;
      frame_count_q <= 32'd0;
      len_q         <= 16'd0;
      dst_q         <= 48'd0;
      src_q         <= 48'd0;
      etype_q       <= 16'd0;
      ifg_q         <= 8'd0;
      seq_q         <= 8'd0;
      off_q         <= 16'd0;
      tdata_q       <= 64'd0;
      tkeep_q       <= 8'd0;
      tlast_q       <= 1'b0;
      tvalid_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      frame_count_q <= frame_count_d;
      len_q         <= len_d;
      dst_q         <= dst_d;
      src_q         <= src_d;
      etype_q       <= etype_d;
      ifg_q         <= ifg_d;
      seq_q         <= seq_d;
      off_q         <= off_d;
      tdata_q       <= tdata_d;
      tkeep_q       <= tkeep_d;
      tlast_q       <= tlast_d;
      tvalid_q      <= tvalid_d;
      busy_q        <= busy_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = 1'b0;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;

endmodule

// File: doc/eth_frame_gen_64.md
Name: eth_frame_gen_64

Overview:
Transmit-side traffic source for the 10G datapath. It builds complete Ethernet frames (header plus a deterministic payload, without FCS) and drives them as a 64-bit AXI stream with tkeep into the tx_axis input of the 10G MAC/FIFO. It is the originating end of the stream; the existing receive/loopback path only consumes frames. It supports a programmable length, header fields, inter-frame gap and backpressure.

Parameters:
MAX_LEN, 1514, largest frame length in bytes excluding FCS; requests above this are clamped to it.
MIN_LEN, 14, smallest frame length (header only); requests below this are clamped to it.
LEN_WIDTH, 16, width of the frame_len input.

Ports:
clk  in  1  single clock (156.25 MHz datapath clock)
rst  in  1  reset, asynchronous, active-low (asserted when 0)
enable  in  1  generate frames while high
frame_len  in  LEN_WIDTH  frame length in bytes, excluding FCS
dst_mac  in  48  destination MAC; [47:40] is transmitted first
src_mac  in  48  source MAC; [47:40] is transmitted first
ethertype  in  16  EtherType; [15:8] is transmitted first
ifg_cycles  in  8  idle cycles between frames
m_axis_tdata  out  64  byte lane 0 = tdata[7:0] = earliest byte
m_axis_tkeep  out  8  valid byte lanes
m_axis_tvalid  out  1  AXI valid
m_axis_tready  in  1  AXI ready
m_axis_tlast  out  1  last beat of the frame
m_axis_tuser  out  1  always 0 (no errored frames)
busy  out  1  high in SEND or GAP
frame_count  out  32  frames fully handed off; wraps modulo 2^32

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; state IDLE. Reset asserted mid-frame aborts the frame immediately, with no tlast.
- All outputs are registered. No combinational path from tready to any output.
- States and transitions:
  - IDLE: if enable=1, latch frame_len (clamped), dst_mac, src_mac, ethertype, ifg_cycles and seq = frame_count[7:0], then go to SEND. tvalid rises the cycle after enable is sampled high.
  - SEND: one beat per handshake (tvalid & tready).
    - Beats = ceil(L/8), where L is the clamped length.
    - Bytes 0-5 = dst_mac, 6-11 = src_mac, 12-13 = ethertype.
    - Payload byte k (frame byte 14+k) = (seq+k) mod 256.
    - Non-last beats: tkeep = 8'hff. Last beat: tkeep = 8'hff >> ((8 - L%8) % 8), and tlast = 1.
    - Bytes in invalid lanes are 0.
  - On the last-beat handshake: frame_count increments.
    - If ifg_cycles = 0 and enable = 1: latch new config and start the next frame with no bubble; tvalid stays high.
    - Else if ifg_cycles > 0: go to GAP.
    - Else: go to IDLE.
  - GAP: tvalid = 0 for exactly ifg_cycles cycles after the last handshake. Then, if enable = 1, tvalid = 1 on the following cycle with new config latched; otherwise go to IDLE.
- Backpressure: while tvalid=1 and tready=0, tdata/tkeep/tlast are held stable. tvalid never drops mid-frame.
- enable deasserted mid-frame: the current frame completes normally, and no new frame starts.
- Config inputs change mid-frame: no effect until the next latch point.
- frame_len is compared at full LEN_WIDTH before clamping. frame_len = 0 gives L = 14.

Decomposition:
- Shared localparams header:
  - state encodings (IDLE/SEND/GAP)
  - header length 14
  - byte-lane count 8
  - the tkeep-from-remainder function
- No sub-module needed. The byte-select logic (header vs payload per lane) is a single function/always block.

Test Plan:
- Basic frame, tready=1: L=60, dst=ffffffffffff, src=020000000001, ethertype=88b5, frame_count=0 → 8 beats; beat0 = 64'h0002ffffffffffff; beat1 = 64'h0100b58801000000; beat7 tkeep = 8'h0f with tlast; frame_count becomes 1.
- Boundary lengths:
  - L=64 → 8 beats, last tkeep = 8'hff.
  - frame_len=5 → clamped to 14: 2 beats, last tkeep = 8'h3f.
  - frame_len=2000 → clamped to 1514: 190 beats, last tkeep = 8'h03.
- Backpressure: random tready at 50% over 10 frames of L=100 → data stable whenever tready=0, byte stream identical to the tready=1 run, frame_count=10.
- Gap: ifg_cycles=3 with enable held → exactly 3 tvalid-low cycles between tlast and the next frame's first beat. ifg_cycles=0 → back-to-back frames, tvalid continuously high, payload seq advancing by 1 per frame.
- enable dropped on beat 2 of an L=60 frame → frame completes with tlast on beat 8, then tvalid stays 0 and frame_count=1.
- rst pulsed low mid-frame → on the same edge, outputs go to 0 and frame_count=0. After release with enable=1, a fresh frame starts with seq=0.
